// File: rtl/io_responder.sv
// CPU I/O responder: services STIN (read_in) from a 1-entry switch buffer and LOUT (write_out)
// into a registered LED word, stalling the core until each request can finish this cycle.
module io_responder #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read_in,
    input  logic             write_out,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             stall,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             timeout_err
);

    localparam int WC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic             in_full;
    logic [WIDTH-1:0] in_buf;
    logic [WC_W-1:0]  wait_cnt;
    logic             timed_out;
    logic             stall_in;
    logic             stall_out;
    logic             rd_ok;

    // A STIN on an empty buffer is released once it has waited TIMEOUT cycles.
    assign timed_out = (TIMEOUT > 0) && (wait_cnt == WC_W'(TIMEOUT));
    assign stall_in  = read_in & ~in_full & ~timed_out;
    assign stall_out = write_out & out_valid & ~out_ready;
    assign stall     = stall_in | stall_out;
    assign rd_ok     = read_in & ~stall;
    assign rd_data   = (rd_ok & in_full) ? in_buf : '0;
    assign in_ready  = ~in_full | rd_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_full     <= 1'b0;
            in_buf      <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            // A refill in the same cycle as a consume keeps the buffer full with the new word.
            if (in_valid & in_ready) begin
                in_buf  <= in_data;
                in_full <= 1'b1;
            end else if (rd_ok) begin
                in_full <= 1'b0;
            end

            if (rd_ok & ~in_full)
                timeout_err <= 1'b1;

            if (write_out & ~stall) begin
                out_data  <= wr_data;
                out_valid <= 1'b1;
            end else if (out_valid & out_ready) begin
                out_valid <= 1'b0;
            end

            if (~read_in | ~stall)
                wait_cnt <= '0;
            else if (stall_in && wait_cnt != '1)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// Drives two responders (wait-forever and TIMEOUT=4) with shared stimulus; a queue-based model
// predicts every cycle's outputs and a negedge monitor compares against each DUT.
module tb_io_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       read_in, write_out, in_valid, out_ready;
    logic [7:0] wr_data, in_data;

    logic [7:0] rd_data0, out_data0, rd_data1, out_data1;
    logic       stall0, in_ready0, out_valid0, terr0;
    logic       stall1, in_ready1, out_valid1, terr1;

    always #5 clk = ~clk;

    io_responder #(.WIDTH(8), .TIMEOUT(0)) dut0 (
        .clk(clk), .reset(reset), .read_in(read_in), .write_out(write_out),
        .wr_data(wr_data), .rd_data(rd_data0), .stall(stall0), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready0), .out_data(out_data0),
        .out_valid(out_valid0), .out_ready(out_ready), .timeout_err(terr0)
    );

    io_responder #(.WIDTH(8), .TIMEOUT(4)) dut1 (
        .clk(clk), .reset(reset), .read_in(read_in), .write_out(write_out),
        .wr_data(wr_data), .rd_data(rd_data1), .stall(stall1), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready1), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(out_ready), .timeout_err(terr1)
    );

    typedef struct {
        logic       stall;
        logic [7:0] rd;
        logic       in_ready;
        logic       out_valid;
        logic [7:0] out_data;
        logic       terr;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int tests = 0;
    int fails = 0;

    // Reference model: buffered switch word, pending LED word, cycles waited, sticky error.
    int   m_to[2] = '{0, 4};
    bit   m_has[2];
    byte  m_buf[2];
    bit   m_led[2];
    byte  m_led_w[2];
    int   m_wait[2];
    bit   m_err[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_has[i] = 0; m_buf[i] = 0; m_led[i] = 0; m_led_w[i] = 0;
            m_wait[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic model_step(input int i, output exp_t e);
        bit timed, stin_ok, lout_ok, done;
        timed   = (m_to[i] > 0) && (m_wait[i] >= m_to[i]);
        stin_ok = m_has[i] || timed;
        lout_ok = !m_led[i] || out_ready;
        e.stall = (read_in && !stin_ok) || (write_out && !lout_ok);
        done    = !e.stall;
        e.rd        = (read_in && done && m_has[i]) ? m_buf[i] : 8'h00;
        e.in_ready  = !m_has[i] || (read_in && done);
        e.out_valid = m_led[i];
        e.out_data  = m_led_w[i];
        e.terr      = m_err[i];
        if (read_in && done) begin
            if (m_has[i]) m_has[i] = 0;
            else          m_err[i] = 1;
        end
        if (in_valid && e.in_ready) begin
            m_has[i] = 1;
            m_buf[i] = in_data;
        end
        if (m_led[i] && out_ready) m_led[i] = 0;
        if (write_out && done) begin
            m_led[i]   = 1;
            m_led_w[i] = wr_data;
        end
        if (!read_in || done) m_wait[i] = 0;
        else if (!stin_ok)    m_wait[i]++;
    endtask

    task automatic drive(input logic ri, input logic wo, input logic [7:0] wd,
                         input logic iv, input logic [7:0] id, input logic ordy);
        exp_t e0, e1;
        @(posedge clk); #1;
        reset = 0; read_in = ri; write_out = wo; wr_data = wd;
        in_valid = iv; in_data = id; out_ready = ordy;
        model_step(0, e0); q0.push_back(e0);
        model_step(1, e1); q1.push_back(e1);
    endtask

    task automatic do_reset(input logic ri, input logic wo);
        @(posedge clk); #1;
        reset = 1; read_in = ri; write_out = wo; wr_data = 8'hEE;
        in_valid = 1; in_data = 8'hDD; out_ready = 0;
        model_reset();
    endtask

    task automatic chk(input string nm, input int d, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL dut%0d %s: got %h expected %h at %0t", d, nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("stall",     0, {7'd0, stall0},     {7'd0, e.stall});
            chk("rd_data",   0, rd_data0,           e.rd);
            chk("in_ready",  0, {7'd0, in_ready0},  {7'd0, e.in_ready});
            chk("out_valid", 0, {7'd0, out_valid0}, {7'd0, e.out_valid});
            chk("out_data",  0, out_data0,          e.out_data);
            chk("timeout",   0, {7'd0, terr0},      {7'd0, e.terr});
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("stall",     1, {7'd0, stall1},     {7'd0, e.stall});
            chk("rd_data",   1, rd_data1,           e.rd);
            chk("in_ready",  1, {7'd0, in_ready1},  {7'd0, e.in_ready});
            chk("out_valid", 1, {7'd0, out_valid1}, {7'd0, e.out_valid});
            chk("out_data",  1, out_data1,          e.out_data);
            chk("timeout",   1, {7'd0, terr1},      {7'd0, e.terr});
        end
    end

    initial begin
        reset = 1; read_in = 0; write_out = 0; wr_data = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        model_reset();
        do_reset(0, 0);
        drive(0, 0, 8'h00, 0, 8'h00, 0);

        // Buffered word consumed by STIN without stall
        drive(0, 0, 8'h00, 1, 8'hA5, 0);
        drive(1, 0, 8'h00, 0, 8'h00, 0);
        drive(0, 0, 8'h00, 0, 8'h00, 0);

        // STIN on empty buffer, word arrives on 4th stall cycle
        repeat (3) drive(1, 0, 8'h00, 0, 8'h00, 0);
        drive(1, 0, 8'h00, 1, 8'h3C, 0);
        drive(1, 0, 8'h00, 0, 8'h00, 0);
        drive(0, 0, 8'h00, 0, 8'h00, 0);

        // LOUT backpressure
        drive(0, 1, 8'h81, 0, 8'h00, 0);
        repeat (2) drive(0, 1, 8'h42, 0, 8'h00, 0);
        drive(0, 1, 8'h42, 0, 8'h00, 1);
        drive(0, 0, 8'h00, 0, 8'h00, 0);
        drive(0, 0, 8'h00, 0, 8'h00, 1);
        drive(0, 0, 8'h00, 0, 8'h00, 0);

        // Timeout on the TIMEOUT=4 instance; the other keeps stalling
        repeat (6) drive(1, 0, 8'h00, 0, 8'h00, 0);
        drive(0, 0, 8'h00, 0, 8'h00, 0);

        // Simultaneous consume and refill
        drive(0, 0, 8'h00, 1, 8'h11, 0);
        drive(1, 0, 8'h00, 1, 8'h22, 0);
        drive(1, 0, 8'h00, 0, 8'h00, 0);
        drive(0, 0, 8'h00, 0, 8'h00, 0);

        // Reset in the middle of LOUT and STIN stalls
        drive(0, 1, 8'h55, 0, 8'h00, 0);
        drive(1, 1, 8'h66, 0, 8'h00, 0);
        drive(1, 1, 8'h66, 0, 8'h00, 0);
        do_reset(1, 1);
        drive(0, 0, 8'h00, 0, 8'h00, 0);
        drive(1, 0, 8'h00, 0, 8'h00, 0);
        drive(0, 0, 8'h00, 0, 8'h00, 0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 2000; n++) begin
            logic ri, wo;
            int   op;
            op = $urandom_range(0, 9);
            ri = (op < 4) || (op == 9);
            wo = (op >= 4 && op < 8) || (op == 9);
            if ($urandom_range(0, 299) == 0)
                do_reset(ri, wo);
            else
                drive(ri, wo, 8'($urandom), ($urandom_range(0, 2) == 0), 8'($urandom),
                      ($urandom_range(0, 1) == 0));
        end

        drive(0, 0, 8'h00, 0, 8'h00, 1);
        @(posedge clk);
        @(posedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain: %0d/%0d expectations left, required 0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
